// File: rtl/lsu_if.sv
// Data-memory request/acknowledge bus between the load/store unit and memory.
// The LSU drives the request side; memory returns ack and read data.
interface lsu_if #(
    parameter int unsigned XLEN = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN/8-1:0] dmem_wstrb;
    logic              dmem_ack;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one memory instruction at a time, lane-aligned stores, extended loads.
// Misaligned or unsupported-width accesses complete without touching memory.
module lsu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            s_load,
    input  logic            s_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] offset,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] mem_addr,
    output logic [2:0]      funct3_out,
    output logic            load_out,
    output logic            store_out,
    output logic            done,
    output logic            misalign,
    output logic [XLEN-1:0] load_data,
    lsu_if.master           dmem
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state;
    logic [XLEN-1:0]   eff_addr;
    logic              accept;
    logic              supported;
    logic              misaligned;
    logic [XLEN-1:0]   wdata_n;
    logic [XLEN/8-1:0] wstrb_n;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_ext;

    always_comb begin
        eff_addr   = base + offset;
        accept     = req_valid & req_ready & (s_load ^ s_store);
        supported  = s_load ? (funct3[1:0] != 2'b11) : (!funct3[2] && funct3[1:0] != 2'b11);
        misaligned = ((funct3[1:0] == 2'b01) & eff_addr[0]) |
                     ((funct3[1:0] == 2'b10) & (|eff_addr[1:0]));
        wdata_n = store_data;
        wstrb_n = '1;
        unique case (funct3[1:0])
            2'b00: begin
                wdata_n = {(XLEN/8){store_data[7:0]}};
                wstrb_n = {{(XLEN/8-1){1'b0}}, 1'b1} << eff_addr[1:0];
            end
            2'b01: begin
                wdata_n = {(XLEN/16){store_data[15:0]}};
                wstrb_n = {{(XLEN/8-2){1'b0}}, 2'b11} << eff_addr[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted  = dmem.dmem_rdata >> {mem_addr[1:0], 3'b000};
        load_ext = shifted;
        unique case (funct3_out[1:0])
            2'b00:   load_ext = {{(XLEN-8){~funct3_out[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{(XLEN-16){~funct3_out[2] & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= StIdle;
            req_ready       <= 1'b0;
            mem_addr        <= '0;
            funct3_out      <= '0;
            load_out        <= 1'b0;
            store_out       <= 1'b0;
            done            <= 1'b0;
            misalign        <= 1'b0;
            load_data       <= '0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_wstrb <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    done     <= 1'b0;
                    misalign <= 1'b0;
                    if (accept) begin
                        req_ready  <= 1'b0;
                        mem_addr   <= eff_addr;
                        funct3_out <= funct3;
                        load_out   <= s_load;
                        store_out  <= s_store;
                        load_data  <= '0;
                        if (!supported) begin
                            done  <= 1'b1;
                            state <= StResp;
                        end else if (misaligned) begin
                            done     <= 1'b1;
                            misalign <= 1'b1;
                            state    <= StResp;
                        end else begin
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= s_store;
                            dmem.dmem_addr  <= {eff_addr[XLEN-1:2], 2'b00};
                            dmem.dmem_wdata <= s_store ? wdata_n : '0;
                            dmem.dmem_wstrb <= s_store ? wstrb_n : '0;
                            state           <= StAccess;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                StAccess: begin
                    if (dmem.dmem_ack) begin
                        dmem.dmem_req   <= 1'b0;
                        dmem.dmem_we    <= 1'b0;
                        dmem.dmem_wstrb <= '0;
                        done            <= 1'b1;
                        load_data       <= load_out ? load_ext : '0;
                        state           <= StResp;
                    end
                end
                StResp: begin
                    done      <= 1'b0;
                    misalign  <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-issue RISC-V core. It sits between execute and the CSR/trap logic. It takes one memory instruction at a time, computes the effective address, and runs a request/acknowledge transaction on the data-memory port. Loads are byte-lane aligned and sign- or zero-extended. Misaligned accesses are never sent to memory; they are reported to the CSR block, which raises load/store-misaligned traps (mcause 4/6, mtval = mem_addr).

## Interface
Parameters:
- XLEN, 32, datapath and address width; data-memory word is XLEN bits, XLEN/8 byte strobes.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  execute presents a memory instruction
- req_ready  out  1  high only in IDLE with reset deasserted (reset=1)
- s_load  in  1  instruction is a load
- s_store  in  1  instruction is a store
- funct3  in  3  width code: LB 000, LH 001, LW 010, LBU 100, LHU 101, LWU 110; SB 000, SH 001, SW 010
- base  in  XLEN  rs1 value
- offset  in  XLEN  sign-extended immediate
- store_data  in  XLEN  rs2 value
- mem_addr  out  XLEN  registered effective address, base+offset mod 2^XLEN
- funct3_out  out  3  registered funct3, feeds CSR misalign check
- load_out, store_out  out  1 each  registered s_load/s_store
- done  out  1  one-cycle completion pulse
- misalign  out  1  valid with done; access was misaligned and not issued
- load_data  out  XLEN  extended load result, valid with done
- dmem_req  out  1  memory request, held until acknowledged
- dmem_we  out  1  1 = write
- dmem_addr  out  XLEN  word-aligned address {mem_addr[XLEN-1:2],2'b00}
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_wstrb  out  XLEN/8  byte enables (0 on reads)
- dmem_ack  in  1  memory completes the current request
- dmem_rdata  in  XLEN  read word, valid with dmem_ack

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: a handshake (req_valid & req_ready) with exactly one of s_load/s_store set registers mem_addr, funct3, flags and store_data. Requests with neither or both flags set are ignored.
- Misaligned access: halfword with addr[0]≠0, or word with addr[1:0]≠0.
  - IDLE → RESP, misalign=1, no dmem_req.
  - Byte accesses are never misaligned.
- Unsupported width code (load 011/111; store ≥011): IDLE → RESP, misalign=0, load_data=0, no memory access.
- Otherwise IDLE → ACCESS.
  - dmem_req=1; dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are constant while dmem_req is high.
  - Leave ACCESS on the first edge that samples dmem_ack=1; capture dmem_rdata on that edge.
- Store lanes (o = mem_addr[1:0]):
  - SB: wdata = {4{sd[7:0]}}, wstrb = 4'b0001<<o.
  - SH: wdata = {2{sd[15:0]}}, wstrb = 4'b0011<<o.
  - SW: wdata = sd, wstrb = 4'b1111.
- Load: shifted = rdata >> (8·o).
  - LB/LBU: sign- or zero-extend shifted[7:0].
  - LH/LHU: sign- or zero-extend shifted[15:0].
  - LW/LWU: shifted.
- Stores: load_data = 0.
- RESP: done=1 for one cycle, then IDLE.
- mem_addr, funct3_out, load_out and store_out hold their values from the accept cycle through done.
- dmem_ack outside ACCESS is ignored.

## Timing
- Reset (reset=0 sampled on an edge), from any state, next cycle:
  - State is IDLE.
  - All outputs are 0: req_ready, done, misalign, dmem_req, dmem_we, dmem_wstrb, dmem_wdata, dmem_addr, mem_addr, load_data, funct3_out, load_out, store_out.
  - An in-flight request is abandoned and dmem_req drops.
  - req_ready rises the first cycle reset=1 is sampled.
- Accept at edge T. dmem_req is high from T+1.
- Zero-wait ack (dmem_ack=1 in cycle T+1): done in cycle T+2.
- Each wait cycle adds one cycle.
- Misaligned or unsupported request: done in cycle T+1.
- req_ready is 0 from T+1 through the done cycle. The next accept is possible in the cycle after done, so the throughput limit is one access per 3 cycles.

## Test plan
- Reset: hold reset=0 for 2 cycles with dmem_ack=1 and req_valid=1 → all outputs 0, no accept. After release, req_ready=1.
- LB: base=0x1000, offset=0x3, mem word 0x80FF_1234, zero-wait ack → dmem_addr=0x1000, done at T+2, load_data=0xFFFF_FF80.
- LHU: addr 0x1002, word 0x80FF_1234 → load_data=0x0000_80FF.
- SH: addr 0x2002, store_data=0xDEAD_BEEF, ack after 3 wait cycles → dmem_wdata=0xBEEF_BEEF, dmem_wstrb=4'b1100, dmem_we=1, request stable for 4 cycles, done at T+5.
- Misalign: LW at 0x1001 → no dmem_req, done at T+1, misalign=1, mem_addr=0x0000_1001, load_out=1.
- Reset mid-op: reset=0 while in ACCESS with dmem_ack=0 → dmem_req=0 next cycle, no done. A new SW after release completes normally.
